// File: rtl/fu_lane_dispatch.sv
// Three identical fixed-latency execution lanes fed by the 3-wide issue-to-FU FIFO.
// Each lane captures a packet, counts LATENCY cycles, then holds it until the completion stage acks.
package fu_pkg;
    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [5:0]  dest_tag;
        logic [15:0] data;
    } ISSUE_FU_PACKET;

    typedef enum logic [1:0] {
        LANE_IDLE = 2'd0,
        LANE_BUSY = 2'd1,
        LANE_DONE = 2'd2
    } lane_state_t;
endpackage

module fu_lane_dispatch #(
    parameter int LATENCY = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          squash,
    input  fu_pkg::ISSUE_FU_PACKET [2:0]  fu_pckt_in,
    input  logic [2:0]                    done_ack,
    output logic [2:0]                    rd_EN,
    output logic [2:0]                    lane_done,
    output fu_pkg::ISSUE_FU_PACKET [2:0]  lane_pckt,
    output logic [1:0]                    busy_count,
    output fu_pkg::lane_state_t [2:0]     lane_state
);
    import fu_pkg::*;

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] LOAD_CNT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    lane_state_t [2:0]          state, state_n;
    logic [2:0][CNT_W-1:0]      cnt, cnt_n;
    ISSUE_FU_PACKET [2:0]       pckt, pckt_n;
    logic [2:0]                 accept;

    // Handshake: rd_EN[i] is a request derived only from lane state; the FIFO answers in the
    // same cycle on fu_pckt_in[i], and a transfer happens when rd_EN[i] & fu_pckt_in[i].valid.
    always_comb begin
        rd_EN   = '0;
        accept  = '0;
        state_n = state;
        cnt_n   = cnt;
        pckt_n  = pckt;
        for (int i = 0; i < 3; i++) begin
            rd_EN[i]  = reset & ~squash &
                        ((state[i] == LANE_IDLE) | ((state[i] == LANE_DONE) & done_ack[i]));
            accept[i] = rd_EN[i] & fu_pckt_in[i].valid;
            if (squash) begin
                state_n[i] = LANE_IDLE;
                cnt_n[i]   = '0;
                pckt_n[i]  = '0;
            end else if (accept[i]) begin
                // A single-cycle build skips BUSY and presents the result after one edge.
                state_n[i] = (LATENCY == 1) ? LANE_DONE : LANE_BUSY;
                cnt_n[i]   = LOAD_CNT;
                pckt_n[i]  = fu_pckt_in[i];
            end else begin
                case (state[i])
                    LANE_BUSY: begin
                        if (cnt[i] == '0) state_n[i] = LANE_DONE;
                        else              cnt_n[i]   = cnt[i] - CNT_W'(1);
                    end
                    LANE_DONE: begin
                        if (done_ack[i]) begin
                            state_n[i] = LANE_IDLE;
                            cnt_n[i]   = '0;
                            pckt_n[i]  = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                state[i] <= LANE_IDLE;
                cnt[i]   <= '0;
                pckt[i]  <= '0;
            end
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pckt  <= pckt_n;
        end
    end

    always_comb begin
        busy_count = '0;
        lane_done  = '0;
        for (int i = 0; i < 3; i++) begin
            lane_done[i] = (state[i] == LANE_DONE);
            busy_count   = busy_count + 2'((state[i] != LANE_IDLE) ? 1 : 0);
        end
    end

    assign lane_pckt  = pckt;
    assign lane_state = state;
endmodule

// File: doc/fu_lane_dispatch.md
Name: fu_lane_dispatch

Overview:
- Consumer end of the 3-wide issue-to-FU packet FIFO: owns three identical fixed-latency execution lanes (e.g. the multiplier group).
- Drives the FIFO's per-lane read enables from lane occupancy, captures the packets the FIFO returns and times each one through a LATENCY-cycle countdown.
- Holds each finished packet on a done interface until the completion stage acknowledges it.
- Sits between the issue FIFO and the complete/CDB arbiter.

Parameters:
- LATENCY, 4, execution cycles from packet capture to lane_done; legal range 1..15.
- CNT_W, $clog2(LATENCY+1), countdown counter width; derived, do not override.

Ports:
- clock  input  1  single clock, all state on posedge.
- reset  input  1  synchronous, active-low; sampled on posedge clock.
- squash  input  1  pipeline flush (mispredict); kills all in-flight lane work.
- fu_pckt_in  input  ISSUE_FU_PACKET[2:0]  packets returned by the FIFO for the lanes enabled this cycle; .valid marks a real packet.
- done_ack  input  3  per-lane acknowledge from completion stage.
- rd_EN  output  3  per-lane read request to the FIFO.
- lane_done  output  3  lane holds a finished packet.
- lane_pckt  output  ISSUE_FU_PACKET[2:0]  packet held by each lane; all-zero when lane IDLE.
- busy_count  output  2  number of lanes not IDLE.

Behaviour:
- Per-lane FSM with states IDLE, BUSY, DONE; 4-bit-or-narrower counter cnt[i].
- Reset (reset==0 at posedge):
  - all lanes IDLE, cnt=0, lane_pckt=0.
  - lane_done=0, busy_count=0, rd_EN=0.
  - reset overrides squash and all inputs, including mid-operation.
- rd_EN[i] is combinational and = reset & ~squash & (state==IDLE | (state==DONE & done_ack[i])).
  - It must not depend combinationally on fu_pckt_in, because the FIFO output depends combinationally on rd_EN.
- Capture: lane i accepts when rd_EN[i] & fu_pckt_in[i].valid.
  - rd_EN[i] without a valid packet (FIFO short/empty) is legal. The lane stays IDLE, or goes DONE->IDLE if it was acknowledged.
- Transitions, with squash=0:
  - IDLE + accept: LATENCY==1 -> DONE; else -> BUSY with cnt=LATENCY-2.
  - BUSY: cnt!=0 -> cnt-1; cnt==0 -> DONE.
  - DONE & ~done_ack: hold DONE, packet stable.
  - DONE & done_ack & accept: load new packet, same rules as IDLE+accept (back-to-back, no bubble).
  - DONE & done_ack & no accept: -> IDLE.
- Latency contract: a packet captured at posedge t has lane_done asserted in the cycle after posedge t+LATENCY-1, i.e. exactly LATENCY cycles after the capture cycle.
- done_ack[i] while lane not DONE is ignored.
- lane_done[i] = (state==DONE) & ~squash is not required. lane_done is purely state==DONE (registered). A squash cycle still shows DONE, but the completion stage must not ack under squash; if it does, ack is ignored.
- Squash (reset=1, squash=1):
  - rd_EN=0 that cycle.
  - every lane -> IDLE at the next edge, cnt=0, lane_pckt cleared.
  - squash has priority over done_ack and capture.
- busy_count = number of lanes in BUSY or DONE; registered-state derived; max 3 fits 2 bits.
- Lanes are fully independent; simultaneous capture on all three lanes in one cycle is required.

Test Plan:
- Reset: hold reset=0 3 cycles with fu_pckt_in all valid -> rd_EN=000, lane_done=000, busy_count=0; release -> rd_EN=111 the same cycle.
- Single op, LATENCY=4: valid packet on lane 0 captured at cycle 0 -> lane_done=001 in cycle 4 with lane_pckt[0] equal to the input; rd_EN[0]=0 cycles 1-4; busy_count=1.
- Backpressure then back-to-back: hold done_ack=0 for 5 cycles -> lane_done[1] stays 1, packet stable, rd_EN[1]=0. Then done_ack[1]=1 with a new valid packet -> rd_EN[1]=1 that cycle, new packet captured, lane_done[1]=0 next cycle, new done 4 cycles after capture.
- Partial FIFO: rd_EN=111 with only fu_pckt_in[2].valid=1 -> only lane 2 goes BUSY; busy_count=1; lanes 0 and 1 keep rd_EN=1.
- Squash mid-flight: three lanes at cnt 2, 0, DONE; squash=1 with done_ack=111 -> rd_EN=000 that cycle; all lanes IDLE, busy_count=0, lane_pckt=0 next cycle.
- LATENCY=1 build: capture at cycle 0 -> lane_done in cycle 1. Continuous done_ack=1 with valid input every cycle -> one completion per lane per cycle, rd_EN held 1.
